// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, data word and memory arbiter states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COH    = 2'd1,
    IFETCH = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active request strictly after ptr, wrapping.
module rr_picker #(
  parameter int CPUS = 2,
  parameter int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [CPUS-1:0] grant,
  output logic [IDXW-1:0] idx
);

  logic            found_s;
  logic [IDXW-1:0] cand_s;

  // Scanning from ptr+1 leaves the previous winner as the last candidate.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= CPUS; i++) begin
      cand_s = IDXW'((int'(ptr) + i) % CPUS);
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        idx           = cand_s;
        grant[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between the coherence controller and the icaches:
// coherence has priority and holds the port, icaches rotate, starvation forces a fetch.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                coh_ramREN,
  input  logic                coh_ramWEN,
  input  word_t               coh_ramaddr,
  input  word_t               coh_ramstore,
  input  logic                coh_lock,
  output logic                coh_wait,
  input  logic [CPUS-1:0]     iREN,
  input  word_t [CPUS-1:0]    iaddr,
  output logic [CPUS-1:0]     iwait,
  output word_t [CPUS-1:0]    iload,
  input  word_t               ramload,
  input  ramstate_t           ramstate,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore
);

  localparam int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CNTW = $clog2(STARVE_LIMIT + 1);

  arb_state_t      state_r;
  arb_state_t      state_next_s;
  logic [IDXW-1:0] rr_ptr_r;
  logic [IDXW-1:0] owner_r;
  logic [CPUS-1:0] owner_oh_r;
  logic [CNTW-1:0] starve_cnt_r;
  logic [IDXW-1:0] pick_idx_s;
  logic [CPUS-1:0] pick_oh_s;
  logic            coh_req_s;
  logic            access_s;
  logic            starved_s;

  rr_picker #(.CPUS(CPUS), .IDXW(IDXW)) u_picker (
    .req   (iREN),
    .ptr   (rr_ptr_r),
    .grant (pick_oh_s),
    .idx   (pick_idx_s)
  );

  // Next-state decision and RAM/requester output steering from the registered grant.
  always_comb begin
    coh_req_s    = coh_ramREN | coh_ramWEN;
    access_s     = (ramstate == ACCESS);
    starved_s    = (starve_cnt_r == CNTW'(STARVE_LIMIT));
    state_next_s = state_r;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    coh_wait     = 1'b1;
    iwait        = '1;
    iload        = '0;
    case (state_r)
      IDLE: begin
        if (starved_s && (|iREN)) begin
          state_next_s = IFETCH;
        end else if (coh_req_s) begin
          state_next_s = COH;
        end else if (|iREN) begin
          state_next_s = IFETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      COH: begin
        // A simultaneous read and write is illegal; the write is the one honoured.
        ramWEN   = coh_ramWEN;
        ramREN   = coh_ramREN & ~coh_ramWEN;
        ramaddr  = coh_ramaddr;
        ramstore = coh_ramstore;
        coh_wait = ~access_s;
        if (coh_lock || coh_req_s) begin
          state_next_s = COH;
        end else begin
          state_next_s = IDLE;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[owner_r];
        for (int i = 0; i < CPUS; i++) begin
          if (owner_oh_r[i]) begin
            iwait[i] = ~access_s;
            iload[i] = ramload;
          end else begin
            iwait[i] = 1'b1;
            iload[i] = '0;
          end
        end
        if (access_s) begin
          state_next_s = IDLE;
        end else if (!iREN[owner_r]) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = IFETCH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Grant state, owner capture, round-robin pointer and starvation counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      owner_r      <= '0;
      owner_oh_r   <= '0;
      starve_cnt_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == IDLE && state_next_s == IFETCH) begin
        owner_r    <= pick_idx_s;
        owner_oh_r <= pick_oh_s;
      end
      // A flushed fetch leaves the pointer alone so the same icache is not skipped.
      if (state_r == IFETCH && access_s) begin
        rr_ptr_r <= owner_r;
      end
      if (iREN == '0) begin
        starve_cnt_r <= '0;
      end else if (state_r != IFETCH && state_next_s == IFETCH) begin
        starve_cnt_r <= '0;
      end else if (state_r != IFETCH && !starved_s) begin
        starve_cnt_r <= starve_cnt_r + CNTW'(1);
      end
    end
  end

endmodule
